// File: rtl/hex_display_scan_if.sv
// Bus between a display controller and the hex_display_scan scanner.
//   master : drives load/value/lz_blank, observes the scan outputs
//   slave  : the scanner; drives hex/en/digit_sel/pending/frame_done
interface hex_display_scan_if #(
  parameter int unsigned DIGITS = 4
);
  logic                  load;
  logic [4*DIGITS-1:0]   value;
  logic                  lz_blank;
  logic [3:0]            hex;
  logic                  en;
  logic [DIGITS-1:0]     digit_sel;
  logic                  pending;
  logic                  frame_done;

  modport master (
    output load, value, lz_blank,
    input  hex, en, digit_sel, pending, frame_done
  );

  modport slave (
    input  load, value, lz_blank,
    output hex, en, digit_sel, pending, frame_done
  );
endinterface

// File: rtl/hex_display_scan.sv
// Time-multiplexed scanner for a DIGITS-digit common-select 7-segment display.
// Steps one digit per PRESCALE-cycle slot, driving a one-hot digit select, the
// nibble and an enable for the downstream hex decoder. Loaded words are held in
// a shadow register and committed only at frame boundaries; the first BLANK
// cycles of every slot are blanked, and leading zeros can be suppressed.
//   clk       : clock, rising edge
//   rst       : synchronous active-high reset
//   bus.load/value/lz_blank           : update request, new word, lz blanking
//   bus.hex/en/digit_sel              : registered decoder drive
//   bus.pending/frame_done            : word waiting for commit, frame pulse
module hex_display_scan #(
  parameter int unsigned DIGITS   = 4,
  parameter int unsigned PRESCALE = 1000,
  parameter int unsigned BLANK    = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  hex_display_scan_if.slave     bus
);

  localparam int unsigned CntW = $clog2(PRESCALE);
  localparam int unsigned IdxW = $clog2(DIGITS);
  localparam logic [CntW-1:0] CntMax = CntW'(PRESCALE - 1);
  localparam logic [IdxW-1:0] IdxMax = IdxW'(DIGITS - 1);

  // Scan state
  logic [CntW-1:0]     cnt_q, cnt_d;
  logic [IdxW-1:0]     idx_q, idx_d;
  logic [4*DIGITS-1:0] disp_q, disp_d;
  logic [4*DIGITS-1:0] shadow_q, shadow_d;
  logic                pend_q, pend_d;
  logic                wrap_q, wrap_d;  // state just crossed a frame boundary

  // Registered outputs
  logic [3:0]          hex_q, hex_d;
  logic                en_q, en_d;
  logic [DIGITS-1:0]   sel_q, sel_d;
  logic                pending_q, pending_d;
  logic                fd_q, fd_d;

  logic                slot_end, boundary;
  logic [DIGITS-1:0]   upper_zero;
  logic                lz_blanked;

  assign slot_end = (cnt_q == CntMax);
  assign boundary = slot_end && (idx_q == IdxMax);

  always_comb begin
    cnt_d    = slot_end ? '0 : cnt_q + CntW'(1);
    idx_d    = idx_q;
    disp_d   = disp_q;
    shadow_d = shadow_q;
    pend_d   = pend_q;
    wrap_d   = boundary;
    if (slot_end) begin
      idx_d = (idx_q == IdxMax) ? '0 : idx_q + IdxW'(1);
    end
    if (boundary) begin
      // A load landing on the boundary bypasses the shadow entirely.
      if (bus.load) begin
        disp_d = bus.value;
        pend_d = 1'b0;
      end else if (pend_q) begin
        disp_d = shadow_q;
        pend_d = 1'b0;
      end
    end else if (bus.load) begin
      shadow_d = bus.value;
      pend_d   = 1'b1;
    end
  end

  // upper_zero[i]: nibbles i..DIGITS-1 of disp are all zero.
  always_comb begin
    logic acc;
    acc        = 1'b1;
    upper_zero = '0;
    for (int i = int'(DIGITS) - 1; i >= 0; i--) begin
      acc           = acc && (disp_q[4*i +: 4] == 4'h0);
      upper_zero[i] = acc;
    end
  end

  assign lz_blanked = bus.lz_blank && (idx_q != '0) && upper_zero[idx_q];

  always_comb begin
    hex_d     = disp_q[4*idx_q +: 4];
    sel_d     = DIGITS'(1) << idx_q;
    en_d      = (32'(cnt_q) >= BLANK) && !lz_blanked;
    pending_d = pend_q;
    fd_d      = wrap_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q     <= '0;
      idx_q     <= '0;
      disp_q    <= '0;
      shadow_q  <= '0;
      pend_q    <= 1'b0;
      wrap_q    <= 1'b0;
      hex_q     <= '0;
      en_q      <= 1'b0;
      sel_q     <= '0;
      pending_q <= 1'b0;
      fd_q      <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      idx_q     <= idx_d;
      disp_q    <= disp_d;
      shadow_q  <= shadow_d;
      pend_q    <= pend_d;
      wrap_q    <= wrap_d;
      hex_q     <= hex_d;
      en_q      <= en_d;
      sel_q     <= sel_d;
      pending_q <= pending_d;
      fd_q      <= fd_d;
    end
  end

  assign bus.hex        = hex_q;
  assign bus.en         = en_q;
  assign bus.digit_sel  = sel_q;
  assign bus.pending    = pending_q;
  assign bus.frame_done = fd_q;

endmodule

// File: tb/tb_hex_display_scan.sv
// Scoreboard bench for hex_display_scan with DIGITS=4, PRESCALE=8, BLANK=2.
// Stimulus pushes the expected output of every scan cycle into a queue, tagged
// with the cycle it must appear on; a negedge monitor pops and compares.
module tb_hex_display_scan;

  typedef struct {
    int         cyc;
    logic [3:0] sel;
    logic [3:0] hex;
    logic       en;
    logic       pend;
    logic       fd;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  int   cyc = 0;
  int   c0 = 0;
  int   n_tests = 0;
  int   n_fail = 0;
  exp_t q[$];
  exp_t m;

  hex_display_scan_if #(.DIGITS(4)) bus ();

  hex_display_scan #(
    .DIGITS  (4),
    .PRESCALE(8),
    .BLANK   (2)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: outputs are sampled on the falling edge.
  always @(negedge clk) begin
    while (q.size() > 0 && q[0].cyc <= cyc) begin
      m = q.pop_front();
      n_tests++;
      if (m.cyc != cyc || bus.digit_sel !== m.sel || bus.hex !== m.hex ||
          bus.en !== m.en || bus.pending !== m.pend || bus.frame_done !== m.fd) begin
        n_fail++;
        $display("FAIL scan@cyc%0d (exp cyc%0d): got sel=%b hex=%h en=%b pend=%b fd=%b, want sel=%b hex=%h en=%b pend=%b fd=%b",
                 cyc, m.cyc, bus.digit_sel, bus.hex, bus.en, bus.pending, bus.frame_done,
                 m.sel, m.hex, m.en, m.pend, m.fd);
      end
    end
  end

  task automatic push_reset(input int c);
    exp_t e;
    e.cyc = c; e.sel = 4'b0000; e.hex = 4'h0; e.en = 1'b0; e.pend = 1'b0; e.fd = 1'b0;
    q.push_back(e);
  endtask

  // One frame of expectations. hx lists the hand-computed digits (digit 3..0),
  // mask the digits that should be enabled, [plo,phi] the scan cycles with pending.
  task automatic push_frame(input int base, input int f, input logic [15:0] hx,
                            input logic [3:0] mask, input int plo, input int phi,
                            input int glim);
    for (int g = f * 32; g < f * 32 + 32 && g <= glim; g++) begin
      exp_t e;
      int   d;
      int   c;
      logic [3:0] one;
      d      = (g / 8) % 4;
      c      = g % 8;
      one    = 4'b0001;
      e.cyc  = base + 1 + g;
      e.sel  = one << d;
      e.hex  = hx[4*d +: 4];
      e.en   = (c >= 2) && mask[d];
      e.pend = (g >= plo) && (g <= phi);
      e.fd   = (g % 32 == 0) && (g > 0);
      q.push_back(e);
    end
  endtask

  // Advance to #1 after scan-state position k (posedge c0+k).
  task automatic goto(input int k);
    while (cyc < c0 + k) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_load(input int k, input logic [15:0] v);
    goto(k);
    bus.load  = 1'b1;
    bus.value = v;
    goto(k + 1);
    bus.load  = 1'b0;
  endtask

  initial begin
    int c1;
    rst          = 1'b1;
    bus.load     = 1'b0;
    bus.value    = 16'h0000;
    bus.lz_blank = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    c0 = cyc;
    push_reset(c0);
    rst = 1'b0;

    // Idle frames, then load mid-frame (digit 1 slot of frame 1).
    push_frame(c0, 0, 16'h0000, 4'b1111, 1, 0, 9999);
    push_frame(c0, 1, 16'h0000, 4'b1111, 41, 63, 9999);
    push_frame(c0, 2, 16'hA3F0, 4'b1111, 71, 95, 9999);
    do_load(40, 16'hA3F0);

    // Two loads in one frame: last wins.
    push_frame(c0, 3, 16'h5678, 4'b1111, 1, 0, 9999);
    do_load(70, 16'h1234);
    do_load(80, 16'h5678);

    // Load exactly on the boundary cycle.
    push_frame(c0, 4, 16'h00C0, 4'b1111, 131, 159, 9999);
    do_load(127, 16'h00C0);

    // Leading-zero blanking on 0050, then on 0000.
    push_frame(c0, 5, 16'h0050, 4'b0011, 166, 191, 9999);
    push_frame(c0, 6, 16'h0000, 4'b0001, 1, 0, 9999);
    do_load(130, 16'h0050);
    goto(160);
    bus.lz_blank = 1'b1;
    do_load(165, 16'h0000);

    // Reset while a word is pending.
    push_frame(c0, 7, 16'h0000, 4'b0001, 231, 239, 239);
    do_load(230, 16'hBEEF);
    goto(240);
    rst          = 1'b1;
    bus.lz_blank = 1'b0;
    goto(241);
    rst = 1'b0;
    c1  = cyc;
    push_reset(c1);
    push_frame(c1, 0, 16'h0000, 4'b1111, 1, 0, 9999);
    push_frame(c1, 1, 16'h0000, 4'b1111, 1, 0, 9999);

    for (int i = 0; i < 200 && q.size() > 0; i++) @(posedge clk);
    if (q.size() > 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL drain: %0d expectations left, want 0", q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
